// File: rtl/l1b_onbellek.sv
// l1b_onbellek: direct-mapped L1 instruction cache with 16-byte lines, 4-beat refill and fence.i flush.
// Optional early restart (deliver the requested word mid-fill) under `L1B_ERKEN_YANIT_EN`.
module l1b_onbellek #(
  parameter int unsigned SATIR_SAYISI = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cek_sec_n_i,
  input  logic [31:0] cek_adr_i,
  output logic        cek_bekle_o,
  output logic [31:0] cek_deger_o,
  input  logic        temizle_i,
  output logic        bel_istek_o,
  output logic [31:0] bel_adr_o,
  input  logic        bel_gecerli_i,
  input  logic [31:0] bel_deger_i
);

  localparam int unsigned IdxW = $clog2(SATIR_SAYISI);
  localparam int unsigned TagW = 28 - IdxW;

  localparam logic [1:0] StBosta  = 2'd0;
  localparam logic [1:0] StDoldur = 2'd1;
  localparam logic [1:0] StYanit  = 2'd2;
`ifdef L1B_ERKEN_YANIT_EN
  localparam logic [1:0] StTekrar = 2'd3;
`endif

  logic [1:0]              durum_q, durum_d;
  logic                    lookup_q;
  logic [31:2]             adr_q;
  logic [31:4]             fill_adr_q;
  logic [1:0]              fill_word_q;
  logic [1:0]              cnt_q;
  logic [3:0][31:0]        buf_q;
  logic [SATIR_SAYISI-1:0] valid_q;
  logic                    flush_pend_q;
  logic [31:0]             son_q;

  logic [TagW-1:0]         tag_mem  [SATIR_SAYISI];
  logic [3:0][31:0]        data_mem [SATIR_SAYISI];
  logic [TagW-1:0]         rd_tag_q;
  logic [31:0]             rd_data_q;

  logic [IdxW-1:0] req_idx, fill_idx, rd_idx;
  logic [TagW-1:0] req_tag, fill_tag;
  logic [1:0]      rd_word;
  logic            hit, miss, beat, son_beat, accept, rd_en, tekrar;
  logic            unused_adr;

  assign unused_adr = ^cek_adr_i[1:0];

  assign req_idx  = adr_q[4 +: IdxW];
  assign req_tag  = adr_q[31 -: TagW];
  assign fill_idx = fill_adr_q[4 +: IdxW];
  assign fill_tag = fill_adr_q[31 -: TagW];

  assign hit      = valid_q[req_idx] && (rd_tag_q == req_tag);
  assign miss     = (durum_q == StBosta) && lookup_q && !hit;
  assign beat     = (durum_q == StDoldur) && bel_gecerli_i;
  assign son_beat = beat && (cnt_q == 2'd3);
  assign accept   = !cek_sec_n_i && !cek_bekle_o;

`ifdef L1B_ERKEN_YANIT_EN
  logic erken_q, teslim_q, pend_q, erken_d;

  assign tekrar  = (durum_q == StTekrar);
  // The last word has no "early" cycle; it is answered from YANIT as usual.
  assign erken_d = beat && (cnt_q == fill_word_q) && (cnt_q != 2'd3);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      erken_q  <= 1'b0;
      teslim_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      erken_q <= erken_d;
      if (miss)         teslim_q <= 1'b0;
      else if (erken_d) teslim_q <= 1'b1;
      if ((durum_q == StDoldur) && accept) pend_q <= 1'b1;
      else if (tekrar)                     pend_q <= 1'b0;
    end
  end
`else
  assign tekrar = 1'b0;
`endif

  // Lookups start from the fetch port, or from the held request when re-reading after a fill.
  assign rd_en   = (accept && ((durum_q == StBosta) || (durum_q == StYanit))) || tekrar;
  assign rd_idx  = tekrar ? adr_q[4 +: IdxW] : cek_adr_i[4 +: IdxW];
  assign rd_word = tekrar ? adr_q[3:2] : cek_adr_i[3:2];

  assign bel_istek_o = (durum_q == StDoldur);
  assign bel_adr_o   = {fill_adr_q, 4'b0000};

  always_comb begin
    cek_bekle_o = 1'b0;
    cek_deger_o = son_q;
    case (durum_q)
      StBosta: begin
        if (lookup_q) begin
          if (hit) cek_deger_o = rd_data_q;
          else     cek_bekle_o = 1'b1;
        end
      end
      StDoldur: begin
        cek_bekle_o = 1'b1;
`ifdef L1B_ERKEN_YANIT_EN
        if (erken_q) begin
          cek_bekle_o = 1'b0;
          cek_deger_o = buf_q[fill_word_q];
        end
`endif
      end
      StYanit: cek_deger_o = buf_q[fill_word_q];
      default: cek_bekle_o = 1'b1;
    endcase
  end

  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      StBosta: if (miss) durum_d = StDoldur;
      StDoldur: begin
        if (son_beat) begin
`ifdef L1B_ERKEN_YANIT_EN
          if (pend_q || accept) durum_d = StTekrar;
          else if (teslim_q)    durum_d = StBosta;
          else                  durum_d = StYanit;
`else
          durum_d = StYanit;
`endif
        end
      end
      default: durum_d = StBosta;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q      <= StBosta;
      lookup_q     <= 1'b0;
      adr_q        <= '0;
      fill_adr_q   <= '0;
      fill_word_q  <= '0;
      cnt_q        <= '0;
      buf_q        <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      son_q        <= '0;
    end else begin
      durum_q  <= durum_d;
      lookup_q <= rd_en;
      son_q    <= cek_deger_o;
      if (accept) adr_q <= cek_adr_i[31:2];
      if (miss) begin
        fill_adr_q  <= adr_q[31:4];
        fill_word_q <= adr_q[3:2];
        cnt_q       <= '0;
      end
      if (beat) begin
        buf_q[cnt_q] <= bel_deger_i;
        cnt_q        <= cnt_q + 2'd1;
      end
      // A flush seen during a fill is held back and also leaves the new line invalid.
      if (son_beat) begin
        flush_pend_q <= 1'b0;
        if (flush_pend_q || temizle_i) valid_q <= '0;
        else                           valid_q[fill_idx] <= 1'b1;
      end else if (temizle_i) begin
        if (durum_q == StDoldur) flush_pend_q <= 1'b1;
        else                     valid_q <= '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (beat)     data_mem[fill_idx][cnt_q] <= bel_deger_i;
    if (son_beat) tag_mem[fill_idx] <= fill_tag;
    if (rd_en) begin
      rd_tag_q  <= tag_mem[rd_idx];
      rd_data_q <= data_mem[rd_idx][rd_word];
    end
  end

endmodule

// File: tb/tb_l1b_onbellek.sv
// Directed self-checking bench for l1b_onbellek; also covers early restart when
// L1B_ERKEN_YANIT_EN is defined.
module tb_l1b_onbellek;

  logic        clk = 1'b0;
  logic        rst;
  logic        cek_sec_n;
  logic [31:0] cek_adr;
  logic        cek_bekle;
  logic [31:0] cek_deger;
  logic        temizle;
  logic        bel_istek;
  logic [31:0] bel_adr;
  logic        bel_gecerli;
  logic [31:0] bel_deger;

  int checks = 0;
  int errors = 0;

`ifdef L1B_ERKEN_YANIT_EN
  localparam int ColdCyc = 4;
`else
  localparam int ColdCyc = 6;
`endif

  always #5 clk = ~clk;

  l1b_onbellek #(.SATIR_SAYISI(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cek_sec_n_i  (cek_sec_n),
    .cek_adr_i    (cek_adr),
    .cek_bekle_o  (cek_bekle),
    .cek_deger_o  (cek_deger),
    .temizle_i    (temizle),
    .bel_istek_o  (bel_istek),
    .bel_adr_o    (bel_adr),
    .bel_gecerli_i(bel_gecerli),
    .bel_deger_i  (bel_deger)
  );

  // Core + memory model: issue one fetch, serve any refill (beats base+0..3, 'gap' idle
  // cycles between beats), optionally pulse temizle in loop cycle flush_cyc.
  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] base, input int gap,
                           input int flush_cyc, output logic [31:0] word, output int ans_cyc,
                           output logic missed, output logic [31:0] fadr);
    int   beat_n;
    int   gap_cnt;
    logic answered;
    beat_n   = 0;
    gap_cnt  = 0;
    answered = 1'b0;
    word     = 32'hDEAD_BEEF;
    ans_cyc  = -1;
    missed   = 1'b0;
    fadr     = '0;
    cek_sec_n = 1'b0;
    cek_adr   = addr;
    @(posedge clk); #1;
    for (int c = 1; c <= 100; c++) begin
      bel_gecerli = 1'b0;
      temizle     = (c == flush_cyc);
      if (bel_istek) begin
        missed = 1'b1;
        fadr   = bel_adr;
        if (gap_cnt == 0 && beat_n < 4) begin
          bel_gecerli = 1'b1;
          bel_deger   = base + beat_n;
          beat_n++;
          gap_cnt = gap;
        end else if (gap_cnt > 0) begin
          gap_cnt--;
        end
      end
      @(negedge clk);
      if (!answered && !cek_bekle) begin
        answered  = 1'b1;
        word      = cek_deger;
        ans_cyc   = c;
        cek_sec_n = 1'b1;
      end
      if (answered && !bel_istek) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bel_gecerli = 1'b0;
    temizle     = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (cek_bekle !== 1'b0) begin errors++; $display("FAIL reset_bekle: got %b expected 0", cek_bekle); end
    checks++; if (cek_deger !== 32'h0) begin errors++; $display("FAIL reset_deger: got %h expected 0", cek_deger); end
    checks++; if (bel_istek !== 1'b0) begin errors++; $display("FAIL reset_istek: got %b expected 0", bel_istek); end
    checks++; if (bel_adr !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h expected 0", bel_adr); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cek_bekle !== 1'b0) begin errors++; $display("FAIL idle_bekle: got %b expected 0", cek_bekle); end
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss();
    logic [31:0] w, fa;
    int          cy;
    logic        m;
    run_fetch(32'h0000_0104, 32'hA0, 0, -1, w, cy, m, fa);
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL cold_missed: got %b expected 1", m); end
    checks++; if (fa !== 32'h0000_0100) begin errors++; $display("FAIL cold_fill_adr: got %h expected 00000100", fa); end
    checks++; if (w !== 32'hA1) begin errors++; $display("FAIL cold_word: got %h expected a1", w); end
    checks++; if (cy !== ColdCyc) begin errors++; $display("FAIL cold_latency: got %0d expected %0d", cy, ColdCyc); end
    @(negedge clk);
    checks++; if (cek_deger !== 32'hA1 || cek_bekle !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got %h/%b expected a1/0", cek_deger, cek_bekle);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_hit_stream();
    cek_sec_n = 1'b0;
    cek_adr   = 32'h100;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) cek_adr = 32'h104 + 32'(4 * i);
      else       cek_sec_n = 1'b1;
      @(negedge clk);
      checks++; if (cek_deger !== 32'hA0 + 32'(i) || cek_bekle !== 1'b0 || bel_istek !== 1'b0) begin
        errors++;
        $display("FAIL hit_stream[%0d]: got %h/%b/%b expected %h/0/0", i, cek_deger, cek_bekle,
                 bel_istek, 32'hA0 + 32'(i));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (cek_deger !== 32'hA3) begin errors++; $display("FAIL hit_hold: got %h expected a3", cek_deger); end
    @(posedge clk); #1;
  endtask

  task automatic test_conflict();
    logic [31:0] w, fa;
    int          cy;
    logic        m;
    run_fetch(32'h100, 32'h0, 0, -1, w, cy, m, fa);
    checks++; if (m !== 1'b0 || w !== 32'hA0) begin errors++; $display("FAIL conf_hit: got %b/%h expected 0/a0", m, w); end
    run_fetch(32'h500, 32'hB0, 0, -1, w, cy, m, fa);
    checks++; if (m !== 1'b1 || fa !== 32'h500 || w !== 32'hB0) begin
      errors++; $display("FAIL conf_alias: got %b/%h/%h expected 1/500/b0", m, fa, w);
    end
    run_fetch(32'h100, 32'hC0, 0, -1, w, cy, m, fa);
    checks++; if (m !== 1'b1 || w !== 32'hC0) begin errors++; $display("FAIL conf_back: got %b/%h expected 1/c0", m, w); end
    run_fetch(32'h108, 32'h0, 0, -1, w, cy, m, fa);
    checks++; if (m !== 1'b0 || w !== 32'hC2) begin errors++; $display("FAIL conf_rehit: got %b/%h expected 0/c2", m, w); end
  endtask

  task automatic test_flush();
    logic [31:0] w, fa;
    int          cy;
    logic        m;
    run_fetch(32'h200, 32'hE0, 0, 3, w, cy, m, fa);
    checks++; if (m !== 1'b1 || w !== 32'hE0) begin errors++; $display("FAIL flush_fill_word: got %b/%h expected 1/e0", m, w); end
    run_fetch(32'h200, 32'hF0, 0, -1, w, cy, m, fa);
    checks++; if (m !== 1'b1 || w !== 32'hF0) begin errors++; $display("FAIL flush_refetch: got %b/%h expected 1/f0", m, w); end
    run_fetch(32'h100, 32'h90, 0, -1, w, cy, m, fa);
    checks++; if (m !== 1'b1 || w !== 32'h90) begin errors++; $display("FAIL flush_other_line: got %b/%h expected 1/90", m, w); end
    run_fetch(32'h104, 32'h0, 0, 1, w, cy, m, fa);
    checks++; if (m !== 1'b0 || w !== 32'h91) begin errors++; $display("FAIL flush_preclear: got %b/%h expected 0/91", m, w); end
    run_fetch(32'h100, 32'h80, 0, -1, w, cy, m, fa);
    checks++; if (m !== 1'b1 || w !== 32'h80) begin errors++; $display("FAIL flush_idle: got %b/%h expected 1/80", m, w); end
  endtask

  task automatic test_gaps();
    logic [31:0] w, fa;
    int          cy;
    logic        m;
    run_fetch(32'h30C, 32'h60, 3, -1, w, cy, m, fa);
    checks++; if (m !== 1'b1 || fa !== 32'h300 || w !== 32'h63) begin
      errors++; $display("FAIL gap_fill: got %b/%h/%h expected 1/300/63", m, fa, w);
    end
    checks++; if (cy !== 15) begin errors++; $display("FAIL gap_latency: got %0d expected 15", cy); end
    run_fetch(32'h308, 32'h0, 0, -1, w, cy, m, fa);
    checks++; if (m !== 1'b0 || w !== 32'h62) begin errors++; $display("FAIL gap_hit: got %b/%h expected 0/62", m, w); end
  endtask

  task automatic test_reset_fill();
    logic [31:0] w, fa;
    int          cy;
    logic        m;
    cek_sec_n = 1'b0;
    cek_adr   = 32'h404;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bel_gecerli = 1'b1;
    bel_deger   = 32'h1111_1111;
    @(posedge clk); #1;
    bel_deger   = 32'h2222_2222;
    @(posedge clk); #1;
    bel_gecerli = 1'b0;
    checks++; if (bel_istek !== 1'b1 || cek_bekle !== 1'b1) begin
      errors++; $display("FAIL rst_pre: got %b/%b expected 1/1", bel_istek, cek_bekle);
    end
    rst = 1'b0;
    #1;
    checks++; if (bel_istek !== 1'b0 || bel_adr !== 32'h0) begin
      errors++; $display("FAIL rst_mem_side: got %b/%h expected 0/0", bel_istek, bel_adr);
    end
    checks++; if (cek_bekle !== 1'b0 || cek_deger !== 32'h0) begin
      errors++; $display("FAIL rst_core_side: got %b/%h expected 0/0", cek_bekle, cek_deger);
    end
    #1;
    rst       = 1'b1;
    cek_sec_n = 1'b1;
    @(posedge clk); #1;
    run_fetch(32'h404, 32'h70, 0, -1, w, cy, m, fa);
    checks++; if (m !== 1'b1 || w !== 32'h71) begin errors++; $display("FAIL rst_refetch: got %b/%h expected 1/71", m, w); end
    run_fetch(32'h30C, 32'h50, 0, -1, w, cy, m, fa);
    checks++; if (m !== 1'b1 || w !== 32'h53) begin errors++; $display("FAIL rst_invalid: got %b/%h expected 1/53", m, w); end
  endtask

`ifdef L1B_ERKEN_YANIT_EN
  task automatic test_early();
    cek_sec_n = 1'b0;
    cek_adr   = 32'h104;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (cek_bekle !== 1'b1) begin errors++; $display("FAIL early_miss: got %b expected 1", cek_bekle); end
    @(posedge clk); #1;
    bel_gecerli = 1'b1;
    bel_deger   = 32'hA0;
    @(posedge clk); #1;
    bel_deger   = 32'hA1;
    @(posedge clk); #1;
    bel_deger   = 32'hA2;
    cek_adr     = 32'h108;
    @(negedge clk);
    checks++; if (cek_bekle !== 1'b0 || cek_deger !== 32'hA1) begin
      errors++; $display("FAIL early_word: got %b/%h expected 0/a1", cek_bekle, cek_deger);
    end
    @(posedge clk); #1;
    bel_deger = 32'hA3;
    @(negedge clk);
    checks++; if (cek_bekle !== 1'b1) begin errors++; $display("FAIL early_pend: got %b expected 1", cek_bekle); end
    @(posedge clk); #1;
    bel_gecerli = 1'b0;
    @(negedge clk);
    checks++; if (cek_bekle !== 1'b1 || bel_istek !== 1'b0) begin
      errors++; $display("FAIL early_tekrar: got %b/%b expected 1/0", cek_bekle, bel_istek);
    end
    @(posedge clk); #1;
    cek_sec_n = 1'b1;
    @(negedge clk);
    checks++; if (cek_bekle !== 1'b0 || cek_deger !== 32'hA2 || bel_istek !== 1'b0) begin
      errors++; $display("FAIL early_second: got %b/%h/%b expected 0/a2/0", cek_bekle, cek_deger, bel_istek);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst         = 1'b0;
    cek_sec_n   = 1'b1;
    cek_adr     = '0;
    temizle     = 1'b0;
    bel_gecerli = 1'b0;
    bel_deger   = '0;
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_conflict();
    test_flush();
    test_gaps();
    test_reset_fill();
`ifdef L1B_ERKEN_YANIT_EN
    test_early();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 100000");
    $fatal(1);
  end

endmodule
